// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: instruction fetch and data ports share one memory.
// Data normally wins; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  r_starve;
  logic        r_owner_d;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic w_fetch_first;
  logic w_pick_d;
  logic w_pick_if;

  // Fetch only overrides data once it has lost STARVE_MAX arbitrations in a row.
  assign w_fetch_first = i_if_req && (r_starve == STARVE_LIM);
  assign w_pick_d      = i_d_req && !w_fetch_first;
  assign w_pick_if     = i_if_req && !w_pick_d;

  assign o_if_rdata = r_if_rdata;
  assign o_d_rdata  = r_d_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_if_gnt    = 1'b0;
    o_d_gnt     = 1'b0;
    o_if_rvalid = 1'b0;
    o_d_rvalid  = 1'b0;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    o_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        // Grants are gated so every output reads zero while reset is held.
        o_d_gnt  = i_rst_n && w_pick_d;
        o_if_gnt = i_rst_n && w_pick_if;
        if (w_pick_d || w_pick_if) w_next = ACCESS;
      end
      ACCESS: begin
        o_busy      = 1'b1;
        o_mem_en    = 1'b1;
        o_mem_we    = r_we;
        o_mem_addr  = r_addr;
        o_mem_wdata = r_wdata;
        if (r_cnt == 4'd0) w_next = RESP;
      end
      RESP: begin
        o_busy      = 1'b1;
        o_if_rvalid = !r_owner_d;
        o_d_rvalid  = r_owner_d;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= 4'd0;
      r_starve   <= 4'd0;
      r_owner_d  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_if_rdata <= 32'h0;
      r_d_rdata  <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (o_if_gnt || !i_if_req) begin
            r_starve <= 4'd0;
          end else if (o_d_gnt && (r_starve != STARVE_LIM)) begin
            r_starve <= r_starve + 4'd1;
          end
          if (o_d_gnt) begin
            r_owner_d <= 1'b1;
            r_we      <= i_d_we;
            r_addr    <= i_d_addr;
            r_wdata   <= i_d_wdata;
            r_cnt     <= LAT_M1;
          end else if (o_if_gnt) begin
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= i_if_addr;
            r_wdata   <= 32'h0;
            r_cnt     <= LAT_M1;
          end
        end
        ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (!r_owner_d) begin
            r_if_rdata <= i_mem_rdata;
          end else if (!r_we) begin
            r_d_rdata <= i_mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: memory access cycles per transaction (legal range 1-15).
REQ-002 Parameter STARVE_MAX, default 4: consecutive data grants tolerated while fetch is waiting (legal range 1-15).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  instruction-fetch request; held until if_gnt.
REQ-006 if_addr  input  32  fetch address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  one-cycle pulse; if_rdata is valid.
REQ-009 if_rdata  output  32  fetch read data.
REQ-010 d_req  input  1  data-access request; held until d_gnt.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  32  data address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  one-cycle completion pulse, for loads and for stores.
REQ-016 d_rdata  output  32  load data.
REQ-017 mem_en  output  1  shared memory enable.
REQ-018 mem_we  output  1  shared memory write enable.
REQ-019 mem_addr  output  32  shared memory address.
REQ-020 mem_wdata  output  32  shared memory write data.
REQ-021 mem_rdata  input  32  shared memory read data, valid while mem_en is high.
REQ-022 busy  output  1  high in every state except IDLE.

Function
REQ-023 FSM states: IDLE, ACCESS, RESP.
REQ-024 IDLE with any request: exactly one gnt asserted combinationally in that cycle.
  - At the edge: latch owner, address, we and wdata.
  - Load cycle counter with MEM_LAT-1.
  - Move to ACCESS.
REQ-025 IDLE with no request: no gnt; stay in IDLE.
REQ-026 ACCESS behaviour:
  - mem_en = 1.
  - mem_addr, mem_we and mem_wdata driven from the latched values.
  - Counter decrements each cycle.
  - At the edge where counter = 0: capture mem_rdata into the owner's rdata register (loads and fetches only), then move to RESP.
REQ-027 RESP: owner's rvalid = 1 for exactly one cycle; mem_en = 0; next state IDLE.
REQ-028 Timing: gnt in cycle T; mem_en high in cycles T+1 .. T+MEM_LAT; rvalid in cycle T+MEM_LAT+1; earliest next gnt in cycle T+MEM_LAT+2.
REQ-029 Priority: when both requests are present in IDLE, data wins, unless starve_cnt = STARVE_MAX, in which case fetch wins.
REQ-030 starve_cnt (4-bit) update in IDLE:
  - Increments when d_gnt is given while if_req is high; saturates at STARVE_MAX.
  - Clears when if_gnt is given or when if_req is low.
REQ-031 A request deasserted before its gnt has no effect.
REQ-032 Requests arriving in ACCESS or RESP are not granted until the next IDLE.
REQ-033 Stores:
  - mem_we = 1 throughout ACCESS.
  - d_rdata keeps its previous value.
  - d_rvalid still pulses in RESP.
REQ-034 if_rdata and d_rdata hold their last captured value until the next capture for that requester.
REQ-035 mem_we, mem_addr and mem_wdata are 0 whenever mem_en = 0.
REQ-036 A gnt is never asserted outside IDLE; if_gnt and d_gnt are never high together.

Reset
REQ-037 While reset = 0, asynchronously:
  - State goes to IDLE.
  - starve_cnt and counter go to 0.
  - All outputs, including both rdata registers, go to 0.
REQ-038 Reset asserted during ACCESS or RESP aborts the transaction with no rvalid; the first gnt after release follows REQ-024.

Verification
REQ-039 MEM_LAT=2; fetch only, if_addr=0x10, mem_rdata=0x00500093 -> if_gnt in cycle 0, mem_en in cycles 1-2 with mem_addr=0x10, if_rvalid in cycle 3 with if_rdata=0x00500093.
REQ-040 d_req (store, d_addr=0x40, d_wdata=0xDEADBEEF) and if_req both raised in cycle 0 -> d_gnt first, mem_we=1 with mem_wdata=0xDEADBEEF in cycles 1-2, d_rvalid in cycle 3, if_gnt in cycle 4, d_rdata unchanged.
REQ-041 STARVE_MAX=4; d_req and if_req held high continuously -> four d_gnt, then if_gnt, then the cycle repeats; never more than four consecutive d_gnt.
REQ-042 reset driven low in cycle 2 of a load -> mem_en and busy drop immediately, no d_rvalid; after release a held d_req is granted in the first IDLE cycle.
REQ-043 MEM_LAT=1 back-to-back fetches -> if_gnt every 3 cycles; if_rvalid exactly 2 cycles after each if_gnt; busy low only in the grant cycles.
